// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_pkg
//  Description : Shared types and width for the EX-stage multiply/divide unit.
//  Revision    : 1.0
// ============================================================================
package muldiv_pkg;

    localparam int MULDIV_WIDTH = 64;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_UMULH = 2'b01,
        OP_UDIV  = 2'b10,
        OP_SDIV  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } muldiv_state_t;

endpackage
`default_nettype wire

// File: rtl/ex_muldiv_unit_step.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_step
//  Description : One iteration of shift-add multiply or restoring divide on a
//                double-width accumulator.
//  Revision    : 1.0
// ============================================================================
module muldiv_step #(
    parameter int WIDTH = 64
) (
    input  logic                 i_mode_div,
    input  logic [2*WIDTH-1:0]   i_acc,
    input  logic [WIDTH-1:0]     i_operand,
    output logic [2*WIDTH-1:0]   o_acc_next
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_rem_sh;
    logic [WIDTH:0] w_diff;

    always_comb begin
        w_sum    = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_operand} : '0);
        // Shifted remainder needs WIDTH+1 bits; the top bit of w_diff is the borrow.
        w_rem_sh = i_acc[2*WIDTH-1:WIDTH-1];
        w_diff   = w_rem_sh - {1'b0, i_operand};
        if (i_mode_div) begin
            if (!w_diff[WIDTH]) begin
                o_acc_next = {w_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
            end else begin
                o_acc_next = {w_rem_sh[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            o_acc_next = {w_sum, i_acc[WIDTH-1:1]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : ex_muldiv_unit
//  Description : Iterative 64-bit multiply/divide unit for the EX stage; stalls
//                the pipeline while busy and pulses done with the result.
//  Revision    : 1.0
// ============================================================================
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [4:0]       rd_in,
    input  logic             flush,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       rd_out,
    output logic             div_by_zero
);

    muldiv_state_t      r_state, w_state_next;
    muldiv_op_t         r_op, w_op;
    logic [CNT_W-1:0]   r_cnt;
    logic [4:0]         r_rd;
    logic [2*WIDTH-1:0] r_acc, w_acc_next;
    logic [WIDTH-1:0]   r_operand;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_final;
    logic               r_neg, r_done, r_dz;
    logic [WIDTH-1:0]   r_result;
    logic [4:0]         r_rd_out;
    logic               w_accept, w_is_div, w_signed, w_b_zero, w_busy;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_mode_div (r_state == ST_DIV),
        .i_acc      (r_acc),
        .i_operand  (r_operand),
        .o_acc_next (w_acc_next)
    );

    always_comb begin
        w_op     = muldiv_op_t'(op);
        w_accept = (r_state == ST_IDLE) && start && !flush;
        w_is_div = op[1];
        w_signed = (w_op == OP_SDIV);
        w_b_zero = (b_in == '0);
        w_busy   = (r_state == ST_MUL) || (r_state == ST_DIV);
        // Signed divide runs on magnitudes; the sign is restored on the way out.
        w_a_mag  = (w_signed && a_in[WIDTH-1]) ? -a_in : a_in;
        w_b_mag  = (w_signed && b_in[WIDTH-1]) ? -b_in : b_in;
        case (r_op)
            OP_MUL:   w_final = w_acc_next[WIDTH-1:0];
            OP_UMULH: w_final = w_acc_next[2*WIDTH-1:WIDTH];
            default:  w_final = r_neg ? -w_acc_next[WIDTH-1:0] : w_acc_next[WIDTH-1:0];
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (!w_is_div)     w_state_next = ST_MUL;
                    else if (w_b_zero) w_state_next = ST_DONE;
                    else               w_state_next = ST_DIV;
                end
            end
            ST_MUL:  if (r_cnt == '0) w_state_next = ST_DONE;
            ST_DIV:  if (r_cnt == '0) w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
        endcase
        if (flush) w_state_next = ST_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_op      <= OP_MUL;
            r_cnt     <= '0;
            r_rd      <= '0;
            r_acc     <= '0;
            r_operand <= '0;
            r_neg     <= 1'b0;
            r_done    <= 1'b0;
            r_dz      <= 1'b0;
            r_result  <= '0;
            r_rd_out  <= '0;
        end else begin
            r_state <= w_state_next;
            r_done  <= (w_state_next == ST_DONE);
            r_dz    <= 1'b0;
            if (w_accept) begin
                r_op      <= w_op;
                r_rd      <= rd_in;
                r_cnt     <= CNT_W'(WIDTH - 1);
                r_acc     <= {{WIDTH{1'b0}}, (w_is_div ? w_a_mag : a_in)};
                r_operand <= w_is_div ? w_b_mag : b_in;
                r_neg     <= w_signed && (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
                if (w_is_div && w_b_zero) begin
                    r_result <= '0;
                    r_rd_out <= rd_in;
                    r_dz     <= 1'b1;
                end
            end else if (w_busy) begin
                r_acc <= w_acc_next;
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - 1'b1;
                end else if (!flush) begin
                    r_result <= w_final;
                    r_rd_out <= r_rd;
                end
            end
        end
    end

    assign stall       = w_accept || w_busy;
    assign done        = r_done;
    assign div_by_zero = r_dz;
    assign result      = r_result;
    assign rd_out      = r_rd_out;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_muldiv_unit
//  Description : Self-checking bench for ex_muldiv_unit against an arithmetic
//                reference model.
//  Revision    : 1.0
// ============================================================================
module tb_ex_muldiv_unit;

    localparam logic [63:0] c_min = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [1:0]  op;
    logic [63:0] a_in, b_in;
    logic [4:0]  rd_in;
    logic        stall, done, div_by_zero;
    logic [63:0] result;
    logic [4:0]  rd_out;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] r_last_res = '0;

    ex_muldiv_unit #(.WIDTH(64), .CNT_W(7)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
        .rd_in(rd_in), .flush(flush), .stall(stall), .done(done), .result(result),
        .rd_out(rd_out), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] res, output logic dz);
        logic [127:0]       p;
        logic signed [63:0] sa, sb, sq;
        p  = {64'd0, a} * {64'd0, b};
        sa = a;
        sb = b;
        dz = 1'b0;
        res = '0;
        case (o)
            2'd0: res = p[63:0];
            2'd1: res = p[127:64];
            2'd2: if (b == 0) dz = 1'b1; else res = a / b;
            default: begin
                if (b == 0) dz = 1'b1;
                else if (a == c_min && b == '1) res = c_min;
                else begin
                    sq  = sa / sb;
                    res = sq;
                end
            end
        endcase
    endtask

    // Called just after a falling edge; returns just after the falling edge of
    // the first cycle following the done pulse.
    task automatic run_op(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] rd, input string tag);
        logic [63:0] e_res;
        logic        e_dz;
        int          lat;
        bit          stall_ok;
        model(o, a, b, e_res, e_dz);
        start = 1'b1; op = o; a_in = a; b_in = b; rd_in = rd;
        #1;
        check({tag, ".stall_start"}, stall, 1);
        @(negedge clk);
        start = 1'b0;
        a_in  = {$urandom, $urandom};
        b_in  = {$urandom, $urandom};
        rd_in = 5'($urandom);
        lat = 1;
        stall_ok = 1'b1;
        while (!done && lat < 200) begin
            if (!stall) stall_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, lat, e_dz ? 1 : 65);
        check({tag, ".stall_busy"}, stall_ok, 1);
        check({tag, ".stall_done"}, stall, 0);
        check({tag, ".result"}, result, e_res);
        check({tag, ".dbz"}, div_by_zero, e_dz);
        check({tag, ".rd"}, rd_out, rd);
        r_last_res = e_res;
        @(negedge clk);
        check({tag, ".done_low"}, done, 0);
        check({tag, ".result_hold"}, result, e_res);
    endtask

    initial begin
        logic [63:0] ra, rb;
        logic [1:0]  ro;
        bit          saw_done;

        reset = 1'b1; start = 1'b0; flush = 1'b0; op = '0;
        a_in = '0; b_in = '0; rd_in = '0;
        repeat (3) @(negedge clk);
        check("reset.done", done, 0);
        check("reset.result", result, 0);
        check("reset.rd", rd_out, 0);
        check("reset.stall", stall, 0);
        reset = 1'b0;
        @(negedge clk);

        run_op(2'd0, 64'd7, 64'd6, 5'd9, "mul_7x6");
        run_op(2'd1, '1, 64'd2, 5'd1, "umulh_max");
        run_op(2'd0, '1, 64'd2, 5'd2, "mul_max");
        run_op(2'd2, 64'd100, 64'd7, 5'd3, "udiv_100_7");
        run_op(2'd3, -64'sd100, 64'd7, 5'd4, "sdiv_m100_7");
        run_op(2'd3, c_min, '1, 5'd5, "sdiv_min_m1");
        run_op(2'd2, 64'd5, 64'd0, 5'd6, "udiv_by_zero");
        run_op(2'd3, -64'sd5, 64'd0, 5'd7, "sdiv_by_zero");

        // Abort a multiply in cycle 10, restart in cycle 11.
        start = 1'b1; op = 2'd0; a_in = 64'd5; b_in = 64'd5; rd_in = 5'd8;
        @(negedge clk);
        start = 1'b0;
        saw_done = 1'b0;
        repeat (9) begin
            if (done) saw_done = 1'b1;
            @(negedge clk);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush.stall_idle", stall, 0);
        check("flush.no_done", {saw_done, done}, 0);
        check("flush.result_hold", result, r_last_res);
        run_op(2'd0, 64'd3, 64'd3, 5'd10, "mul_after_flush");

        for (int i = 0; i < 14; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 5) == 0) ? c_min : {$urandom, $urandom};
            case ($urandom_range(0, 4))
                0:       rb = '0;
                1:       rb = 64'($urandom_range(1, 20));
                2:       rb = -64'($urandom_range(1, 20));
                3:       rb = '1;
                default: rb = {$urandom, $urandom};
            endcase
            run_op(ro, ra, rb, 5'($urandom), $sformatf("rand%0d", i));
        end

        // Reset in the middle of a divide.
        start = 1'b1; op = 2'd2; a_in = 64'd1000; b_in = 64'd7; rd_in = 5'd12;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midreset.done", done, 0);
        check("midreset.result", result, 0);
        check("midreset.rd", rd_out, 0);
        check("midreset.stall", stall, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_op(2'd2, 64'd9, 64'd3, 5'd13, "udiv_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
